user_irq_debounce: RTL and testbench
====================================

# user_irq_debounce

- Sits between board push-buttons and the Sapphire SoC.
- Synchronises and debounces `WIDTH` raw button inputs.
- Presents clean levels to the SoC GPIO read bus (`system_gpio_0_io_read`).
- Latches edge events into per-channel pending bits and drives the SoC user interrupt line (`userInterruptA`).
- Runs in the SoC system clock domain; reset comes from the SoC's `io_systemReset`.

## Interface

Parameters:
- `WIDTH`, 2: number of button channels.
- `DEBOUNCE_CYCLES`, 500000: cycles an input must hold a new value before it is accepted (10 ms at 50 MHz). Legal range: 1 to 2^`CNT_W`-1.
- `CNT_W`, 20: debounce counter width.

Ports:
- `io_systemClk`, in, 1: the single clock. One clock; all logic on its rising edge.
- `io_systemReset`, in, 1: reset is synchronous and active-high.
- `btn_raw`, in, `WIDTH`: asynchronous raw button inputs, active-high.
- `btn_level`, out, `WIDTH`: debounced stable level per channel; goes to GPIO read bits.
- `irq_mask`, in, `WIDTH`: per-channel interrupt enable, driven from SoC GPIO write bits.
- `irq_clear`, in, `WIDTH`: per-channel pending clear, level-sensitive, driven from SoC GPIO write bits.
- `irq_pending`, out, `WIDTH`: latched event flags.
- `userInterruptA`, out, 1: registered OR of (`irq_pending` & `irq_mask`).

## Operation

Synchroniser, per channel:
- Two-flop chain: `btn_raw` -> `sync1` -> `sync2`.
- Both flops reset to 0.

Debounce, per channel, with registers `stable` and `cnt`:
- If `sync2` == `stable`: `cnt` <= 0.
- If `sync2` != `stable` and `cnt` < `DEBOUNCE_CYCLES`-1: `cnt` <= `cnt`+1.
- If `sync2` != `stable` and `cnt` == `DEBOUNCE_CYCLES`-1: `stable` <= `sync2` and `cnt` <= 0. This is the accept event.
- Any glitch that returns `sync2` to `stable` before acceptance restarts the count from 0.
- `cnt` never exceeds `DEBOUNCE_CYCLES`-1; there is no wrap.

Outputs:
- `btn_level` = `stable`, direct from the register.
- Rise event: an accept event where the new `stable` is 1.

Pending, per channel:
- Set on a qualifying event (see Configuration).
- Cleared on any cycle where `irq_clear[i]`=1 and no event occurs on that cycle.
- Event and clear on the same cycle: the set wins, so no event is lost.
- A bit that is already set stays set on further events; there is no counting.

Interrupt:
- `userInterruptA` <= |(`irq_pending` & `irq_mask`), registered.
- Masking does not affect pending; unmasking a set pending bit asserts the interrupt one cycle later.

Reset (`io_systemReset`=1 at a clock edge):
- `sync1`, `sync2`, `stable`, `cnt`, `irq_pending`, `userInterruptA` all <= 0.
- Therefore `btn_level`=0, `irq_pending`=0, `userInterruptA`=0.
- Reset mid-count discards the partial count.
- A button held through reset is seen as a fresh 0->1 transition after reset and generates an event after the full latency.

## Timing

Latency, with `btn_raw` changing and held from before edge E0:
- Edge E0: `sync1` takes the new value.
- Edge E1: `sync2` takes it.
- Edges E2..: counting. `stable`, `btn_level` and `irq_pending` update at edge E1+`DEBOUNCE_CYCLES`.
- `userInterruptA` updates one edge later, at E2+`DEBOUNCE_CYCLES`.

Clear and mask timing:
- `irq_clear` acts on the next edge.
- `userInterruptA` deasserts one edge after `irq_pending` clears.
- `irq_mask` change to `userInterruptA` change: 1 cycle.

Throughput and edge cases:
- A channel accepts at most one transition per `DEBOUNCE_CYCLES` cycles.
- Channels are fully independent; simultaneous events on several channels all latch on the same edge.
- `DEBOUNCE_CYCLES`=1: the accept event occurs on the first cycle of mismatch.

## Configuration

- Macro: `USER_IRQ_BOTH_EDGES_EN`.
- Defined: pending is set on every accept event, both rising and falling, so press and release each interrupt.
- Undefined (default): pending is set only on rise events; falling accepts update `btn_level` only.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4, `WIDTH`=2.

- Reset: assert `io_systemReset` 2 cycles with `btn_raw`=2'b11 -> `btn_level`=0, `irq_pending`=0, `userInterruptA`=0 during reset; after release, `btn_level`=2'b11 exactly 5 edges later.
- Clean press on ch0 with `irq_mask`=2'b01 -> `btn_level[0]`=1 and `irq_pending[0]`=1 at E5, `userInterruptA`=1 at E6.
- Bounce: ch0 raw high 3 cycles, low 1, high 10 -> only one accept; `irq_pending[0]` set exactly once, 4 cycles after the last `sync2` rise.
- Simultaneous: `irq_clear[0]`=1 on the same edge ch0 accepts a rise -> `irq_pending[0]` stays 1; clear on the following cycle -> 0, then `userInterruptA`=0 one edge later.
- Masking: ch1 event with `irq_mask`=2'b00 -> `irq_pending[1]`=1, `userInterruptA`=0; set `irq_mask[1]` -> `userInterruptA`=1 next edge.
- Release: ch0 release -> `btn_level[0]`=0; `irq_pending[0]` is set only when built with `USER_IRQ_BOTH_EDGES_EN`, otherwise unchanged at 0.

Source files
------------

// File: rtl/user_irq_debounce_if.sv
// Button/interrupt bundle between the debounce block and the SoC GPIO side.
// The SoC (or a bench) drives through master; the debounce block uses slave.
interface user_irq_debounce_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] irq_clear;
    logic [WIDTH-1:0] irq_pending;
    logic             userInterruptA;

    modport master (
        output btn_raw,
        output irq_mask,
        output irq_clear,
        input  btn_level,
        input  irq_pending,
        input  userInterruptA
    );

    modport slave (
        input  btn_raw,
        input  irq_mask,
        input  irq_clear,
        output btn_level,
        output irq_pending,
        output userInterruptA
    );
endinterface

// File: rtl/user_irq_debounce.sv
// Synchronise, debounce and latch per-channel button events into the SoC user IRQ.
// Define USER_IRQ_BOTH_EDGES_EN to latch release events as well as presses.
module user_irq_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                io_systemClk,
    input  logic                io_systemReset,
    user_irq_debounce_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_pending;
    logic             r_irq;

    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_event;

    // NOTE: non-blocking assignments keep this a real two-stage chain; blocking would collapse it.
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // NOTE: default first so no path through the loop leaves w_accept unassigned (no latch).
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

`ifdef USER_IRQ_BOTH_EDGES_EN
    assign w_event = w_accept;
`else
    assign w_event = w_accept & r_sync2;
`endif

    // Counting stops at CNT_LAST because that cycle is always an accept, so no wrap.
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            r_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // An event on the same cycle as a clear wins, so no press is ever lost.
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_event | (r_pending & ~bus.irq_clear);
            r_irq     <= |(r_pending & bus.irq_mask);
        end
    end

    assign bus.btn_level      = r_stable;
    assign bus.irq_pending    = r_pending;
    assign bus.userInterruptA = r_irq;
endmodule

// File: tb/tb_user_irq_debounce.sv
// Scoreboard bench: a sample-history model predicts outputs per edge, a monitor compares.
// Expected values are queued by the stimulus and popped on the following falling edge.
module tb_user_irq_debounce;
    localparam int WIDTH = 2;
    localparam int DC    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    user_irq_debounce_if #(.WIDTH(WIDTH)) bus ();

    user_irq_debounce #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (20)
    ) dut (
        .io_systemClk  (clk),
        .io_systemReset(rst),
        .bus           (bus)
    );

    typedef struct packed {
        logic [WIDTH-1:0] level;
        logic [WIDTH-1:0] pend;
        logic             irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: raw values in flight through the synchroniser, and the
    // synchronised samples seen since each channel's last accepted transition.
    logic [WIDTH-1:0] m_rawq [2];
    bit               m_hist [WIDTH][$];
    logic [WIDTH-1:0] m_stable;
    logic [WIDTH-1:0] m_pend;
    logic             m_irq;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic [WIDTH-1:0] raw, input logic [WIDTH-1:0] mask,
                              input logic [WIDTH-1:0] clr, input logic r);
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] ev;
        logic             irq_next;
        bit               all_diff;
        exp_t             e;
        if (r) begin
            m_rawq[0] = '0;
            m_rawq[1] = '0;
            for (int c = 0; c < WIDTH; c++) m_hist[c].delete();
            m_stable = '0;
            m_pend   = '0;
            m_irq    = 1'b0;
        end else begin
            s         = m_rawq[0];
            m_rawq[0] = m_rawq[1];
            m_rawq[1] = raw;
            irq_next  = |(m_pend & mask);
            ev        = '0;
            for (int c = 0; c < WIDTH; c++) begin
                m_hist[c].push_back(s[c]);
                if (m_hist[c].size() > DC) void'(m_hist[c].pop_front());
                if (m_hist[c].size() == DC) begin
                    all_diff = 1'b1;
                    foreach (m_hist[c][k]) if (m_hist[c][k] == m_stable[c]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_stable[c] = s[c];
`ifdef USER_IRQ_BOTH_EDGES_EN
                        ev[c] = 1'b1;
`else
                        ev[c] = s[c];
`endif
                        m_hist[c].delete();
                    end
                end
            end
            m_pend = ev | (m_pend & ~clr);
            m_irq  = irq_next;
        end
        e.level = m_stable;
        e.pend  = m_pend;
        e.irq   = m_irq;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [WIDTH-1:0] raw, input logic [WIDTH-1:0] mask,
                        input logic [WIDTH-1:0] clr, input logic r);
        @(negedge clk);
        #1;
        bus.btn_raw   = raw;
        bus.irq_mask  = mask;
        bus.irq_clear = clr;
        rst           = r;
        model_edge(raw, mask, clr, r);
    endtask

    task automatic hold(input logic [WIDTH-1:0] raw, input logic [WIDTH-1:0] mask,
                        input logic [WIDTH-1:0] clr, input int n);
        for (int k = 0; k < n; k++) step(raw, mask, clr, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("btn_level",      {2'b00, bus.btn_level},      {2'b00, e.level});
                check("irq_pending",    {2'b00, bus.irq_pending},    {2'b00, e.pend});
                check("userInterruptA", {3'b000, bus.userInterruptA}, {3'b000, e.irq});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [WIDTH-1:0] raw;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] clr;
        bus.btn_raw   = '0;
        bus.irq_mask  = '0;
        bus.irq_clear = '0;

        // Buttons held through reset appear as fresh presses afterwards.
        step(2'b11, 2'b00, 2'b00, 1'b1);
        step(2'b11, 2'b00, 2'b00, 1'b1);
        hold(2'b11, 2'b00, 2'b00, 8);

        step(2'b00, 2'b00, 2'b00, 1'b1);
        step(2'b00, 2'b00, 2'b00, 1'b1);
        hold(2'b00, 2'b01, 2'b00, 3);

        // Clean press, release, then a bounced press on ch0.
        hold(2'b01, 2'b01, 2'b00, 8);
        hold(2'b00, 2'b01, 2'b00, 8);
        hold(2'b00, 2'b01, 2'b01, 2);
        hold(2'b01, 2'b01, 2'b00, 3);
        hold(2'b00, 2'b01, 2'b00, 1);
        hold(2'b01, 2'b01, 2'b00, 10);

        // Clear coinciding with the accept edge, then clear afterwards.
        hold(2'b00, 2'b01, 2'b00, 8);
        hold(2'b00, 2'b01, 2'b01, 2);
        hold(2'b01, 2'b01, 2'b00, 5);
        hold(2'b01, 2'b01, 2'b01, 1);
        hold(2'b01, 2'b01, 2'b01, 1);
        hold(2'b01, 2'b01, 2'b00, 3);

        // Masked ch1 event, then unmask.
        hold(2'b11, 2'b00, 2'b00, 8);
        hold(2'b11, 2'b10, 2'b00, 3);
        hold(2'b11, 2'b00, 2'b00, 2);

        raw  = 2'b11;
        mask = 2'b11;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < WIDTH; c++) begin
                if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
            end
            if ($urandom_range(0, 7) == 0) mask = WIDTH'($urandom);
            clr = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom) : '0;
            step(raw, mask, clr, ($urandom_range(0, 299) == 0));
        end

        @(negedge clk);
        #2;
        check("scoreboard_drain", 4'(exp_q.size()), 4'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
